// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 16-point radix-2 SDF FFT chain: stage counter, datapath advance, handshakes,
// frame flush and output tagging. Define FFT_BITREV_EN to report out_idx in natural bin order.
module fft_seq_ctrl #(
  parameter int N        = 16,
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in_zero,
  output logic             dp_en,
  output logic [LOG2N-2:0] stage_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic             live;
    logic             last;
    logic [LOG2N-1:0] idx;
  } tag_t;

  localparam logic [LOG2N-1:0] LAST_SMP = LOG2N'(N - 1);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] smp_cnt_q, smp_cnt_d;
  tag_t             tag_q [PIPE_LAT];
  tag_t             tag_d [PIPE_LAT];
  tag_t             head;
  tag_t             tag_push;
  logic             stall;
  logic             pipe_live;

  // The head of the tag pipe lines up with the result at the chain output.
  always_comb begin
    head      = tag_q[PIPE_LAT-1];
    out_valid = head.live;
    out_last  = head.live & head.last;
    stall     = out_valid & ~out_ready;
    pipe_live = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      pipe_live = pipe_live | tag_q[i].live;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    in_ready = 1'b0;
    in_zero  = 1'b0;
    dp_en    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        dp_en    = in_valid;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        in_ready = ~stall;
        dp_en    = in_valid & ~stall;
        // A source gap only ends the frame stream at a frame boundary; mid-frame it just waits.
        if (smp_cnt_q == '0 && !in_valid) begin
          state_d = pipe_live ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        in_zero = 1'b1;
        dp_en   = ~stall;
        if (!stall && smp_cnt_q == LAST_SMP) begin
          if (in_valid)       state_d = RUN;
          else if (!pipe_live) state_d = IDLE;
          else                state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    tag_d     = tag_q;
    tag_push  = '{live: ~in_zero, last: (smp_cnt_q == LAST_SMP), idx: smp_cnt_q};
    if (dp_en) begin
      smp_cnt_d = smp_cnt_q + 1'b1;
      tag_d[0]  = tag_push;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      // NOTE: the whole tag pipe is reset so samples in flight at reset never surface as output.
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      tag_q     <= tag_d;
    end
  end

  assign stage_cnt = smp_cnt_q[LOG2N-2:0];
  assign busy      = (state_q != IDLE);

`ifdef FFT_BITREV_EN
  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  // SDF output emerges in bit-reversed order; undo it so out_idx is the bin number.
  assign out_idx = bit_rev(head.idx);
`else
  assign out_idx = head.idx;
`endif

endmodule
